// File: rtl/vga_pkg.sv
// Shared colour constants, camera FSM states and RGB565 reduction for the camera pixel writer.
package vga_pkg;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] WHITE = 3'b111;

    typedef enum logic [1:0] {
        WAIT_VSYNC = 2'd0,
        IN_VSYNC   = 2'd1,
        CAPTURE    = 2'd2
    } cam_state_e;

    // Keep only the MSB of each colour field: {R[4], G[5], B[4]}.
    function automatic logic [2:0] rgb565_to_rgb3(input logic [15:0] rgb);
        return {rgb[15], rgb[10], rgb[4]};
    endfunction

endpackage

// File: rtl/cam_pixel_writer_if.sv
// Camera input bus plus display pop interface of the camera pixel writer.
interface cam_pixel_writer_if #(
    parameter int unsigned LEVEL_W = 11
);
    logic               cam_pclk;
    logic               cam_vsync;
    logic               cam_href;
    logic [7:0]         cam_d;
    logic               read;
    logic [2:0]         data;
    logic               frame_start;
    logic               overflow;
    logic               underflow;
    logic [LEVEL_W-1:0] fifo_level;

    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_d, read,
        input  data, frame_start, overflow, underflow, fifo_level
    );

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_d, read,
        output data, frame_start, overflow, underflow, fifo_level
    );
endinterface

// File: rtl/pixel_fifo.sv
// Single-clock 3-bit pixel FIFO with flush, occupancy level and registered read data.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned LEVEL_W    = 11
) (
    input  logic               clk_25,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [2:0]         wdata,
    input  logic               pop,
    output logic [2:0]         rdata,
    output logic [LEVEL_W-1:0] level
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full_c;
    logic          empty_c;
    logic          do_push_c;
    logic          do_pop_c;

    assign full_c    = (level == LEVEL_W'(FIFO_DEPTH));
    assign empty_c   = (level == '0);
    assign do_push_c = push & ~full_c;
    assign do_pop_c  = pop & ~empty_c;

    // Level is the sole full/empty source; flush overrides any push or pop.
    always_ff @(posedge clk_25) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= BLACK;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end else if (pop) begin
                rdata <= BLACK;
            end
            case ({do_push_c, do_pop_c})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_25) begin
        if (do_push_c && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/cam_pixel_writer.sv
// Camera RGB565 byte stream to 3-bit pixel FIFO, all in clk_25.
// Define CAM_PIXEL_WRITER_TEST_PATTERN_EN to replace camera data with 80-pixel colour bars.
module cam_pixel_writer
    import vga_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 1024,
    parameter int unsigned LEVEL_W    = 11
) (
    input  logic              clk_25,
    input  logic              reset,
    cam_pixel_writer_if.slave bus
);
    localparam int unsigned SYNC_W = 11;

    logic [SYNC_W-1:0] sync1_q;
    logic [SYNC_W-1:0] sync2_q;
    logic              pclk_prev_q;
    logic              href_prev_q;
    logic              pclk_s;
    logic              vsync_s;
    logic              href_s;
    logic [7:0]        d_s;
    logic              pclk_rise_c;
    logic              href_fall_c;

    cam_state_e        state_q;
    cam_state_e        state_d;
    logic              flush_c;
    logic              capture_c;
    logic              push_c;
    logic              phase_q;
    logic [2:0]        pixel_c;

    // All camera lines share one aligned 2-flop synchroniser.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pclk_prev_q <= 1'b0;
            href_prev_q <= 1'b0;
        end else begin
            sync1_q     <= {bus.cam_pclk, bus.cam_vsync, bus.cam_href, bus.cam_d};
            sync2_q     <= sync1_q;
            pclk_prev_q <= pclk_s;
            href_prev_q <= href_s;
        end
    end

    assign pclk_s      = sync2_q[10];
    assign vsync_s     = sync2_q[9];
    assign href_s      = sync2_q[8];
    assign d_s         = sync2_q[7:0];
    assign pclk_rise_c = pclk_s & ~pclk_prev_q;
    assign href_fall_c = href_prev_q & ~href_s;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q <= WAIT_VSYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Any entry into IN_VSYNC is a frame start and flushes the FIFO.
    always_comb begin
        state_d = state_q;
        flush_c = 1'b0;
        case (state_q)
            WAIT_VSYNC: begin
                if (vsync_s) begin
                    state_d = IN_VSYNC;
                    flush_c = 1'b1;
                end
            end
            IN_VSYNC: begin
                if (!vsync_s) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (vsync_s) begin
                    state_d = IN_VSYNC;
                    flush_c = 1'b1;
                end
            end
            default: state_d = WAIT_VSYNC;
        endcase
    end

    assign capture_c = (state_q == CAPTURE) & ~vsync_s & pclk_rise_c & href_s;
    assign push_c    = capture_c & phase_q;

    always_ff @(posedge clk_25) begin
        if (reset || flush_c) begin
            phase_q <= 1'b0;
        end else if (capture_c) begin
            phase_q <= ~phase_q;
        end else if (href_fall_c) begin
            phase_q <= 1'b0;
        end
    end

`ifdef CAM_PIXEL_WRITER_TEST_PATTERN_EN
    localparam int unsigned BAR_LEN = 80;

    logic [6:0] bar_pos_q;
    logic [2:0] bar_q;

    // Bar index advances every BAR_LEN pushes and wraps after 7.
    always_ff @(posedge clk_25) begin
        if (reset || flush_c) begin
            bar_pos_q <= '0;
            bar_q     <= '0;
        end else if (push_c) begin
            if (bar_pos_q == 7'(BAR_LEN - 1)) begin
                bar_pos_q <= '0;
                bar_q     <= bar_q + 3'(1);
            end else begin
                bar_pos_q <= bar_pos_q + 7'(1);
            end
        end
    end

    assign pixel_c = bar_q;
`else
    logic [7:0] hi_q;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            hi_q <= '0;
        end else if (capture_c && !phase_q) begin
            hi_q <= d_s;
        end
    end

    assign pixel_c = rgb565_to_rgb3({hi_q, d_s});
`endif

    pixel_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .LEVEL_W    (LEVEL_W)
    ) u_fifo (
        .clk_25 (clk_25),
        .reset  (reset),
        .flush  (flush_c),
        .push   (push_c),
        .wdata  (pixel_c),
        .pop    (bus.read),
        .rdata  (bus.data),
        .level  (bus.fifo_level)
    );

    always_ff @(posedge clk_25) begin
        if (reset) begin
            bus.frame_start <= 1'b0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
        end else begin
            bus.frame_start <= flush_c;
            bus.overflow    <= push_c & ~flush_c & (bus.fifo_level == LEVEL_W'(FIFO_DEPTH));
            bus.underflow   <= bus.read & ~flush_c & (bus.fifo_level == '0);
        end
    end

endmodule
